// File: rtl/segment_pkg.sv
// Shared definitions for the FIFO drain path: skid-buffer state encodings,
// buffer depth and the buffer state-transition function.
package segment_pkg;

  localparam int         BUF_DEPTH = 2;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_ONE    = 2'd1;
  localparam logic [1:0] ST_TWO    = 2'd2;

  // The encoding doubles as the occupancy count, so callers can do arithmetic on it.
  function automatic logic [1:0] buf_next_state(input logic [1:0] st,
                                                input logic       push,
                                                input logic       pop);
    logic [1:0] nxt;
    nxt = st;
    case (st)
      ST_EMPTY: if (push)         nxt = ST_ONE;
      ST_ONE:   if (push && !pop) nxt = ST_TWO;
                else if (!push && pop) nxt = ST_EMPTY;
      ST_TWO:   if (pop && !push) nxt = ST_ONE;
      default:                    nxt = ST_EMPTY;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry output buffer: head register drives the output directly, tail
// absorbs the word still in flight from the FIFO when the consumer stalls.
module skid_buf
  import segment_pkg::*;
#(
  parameter int BIT_WIDTH = -1
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [BIT_WIDTH-1:0] i_data,
  input  logic                 i_pop,
  output logic                 o_valid,
  output logic [BIT_WIDTH-1:0] o_data,
  output logic [1:0]           o_state
);

  logic [1:0]           r_state;
  logic [BIT_WIDTH-1:0] r_head;
  logic [BIT_WIDTH-1:0] r_tail;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= buf_next_state(r_state, i_push, i_pop);
      case (r_state)
        ST_EMPTY: if (i_push) r_head <= i_data;
        ST_ONE: begin
          if (i_push && i_pop) r_head <= i_data;
          else if (i_push)     r_tail <= i_data;
        end
        // Push without pop in TWO is prevented by the read-issue logic.
        ST_TWO: begin
          if (i_pop) begin
            r_head <= r_tail;
            if (i_push) r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid = (r_state != ST_EMPTY);
  assign o_data  = r_head;
  assign o_state = r_state;

endmodule

// File: rtl/fifo_drain.sv
// Drains an upstream 1-cycle-latency FIFO into a valid/ready stream.
// Optional FIFO_DRAIN_STATS_EN adds a 32-bit popped-word counter (drained_cnt).
module fifo_drain
  import segment_pkg::*;
#(
  parameter int BIT_WIDTH = -1,
  parameter int CNT_BITW  = -1
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [CNT_BITW-1:0]  fifo_count,
  output logic                 fifo_rd_en,
  input  logic [BIT_WIDTH-1:0] fifo_rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data
`ifdef FIFO_DRAIN_STATS_EN
  ,output logic [31:0]         drained_cnt
`endif
);

  logic       r_inflight;
  logic       w_pop;
  logic [1:0] w_state;
  logic [2:0] w_level;

  assign w_pop = out_valid && out_ready;

  // Slots committed after this cycle; pop implies occupancy >= 1, so no wrap.
  assign w_level = {1'b0, w_state} + {2'b0, r_inflight} - {2'b0, w_pop};

  assign fifo_rd_en = !rst && (fifo_count != '0) && (w_level < 3'(BUF_DEPTH));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) r_inflight <= 1'b0;
    else     r_inflight <= fifo_rd_en;
  end

  skid_buf #(.BIT_WIDTH(BIT_WIDTH)) u_buf (
    .clock   (clock),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (fifo_rd_data),
    .i_pop   (w_pop),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_state (w_state)
  );

`ifdef FIFO_DRAIN_STATS_EN
  logic [31:0] r_drained;

  always_ff @(posedge clock or posedge rst) begin
    if (rst)        r_drained <= '0;
    else if (w_pop) r_drained <= r_drained + 32'd1;
  end

  assign drained_cnt = r_drained;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Directed + randomized bench for fifo_drain with a behavioural upstream FIFO
// and an in-order scoreboard of written words.
module tb_fifo_drain;

  localparam int BW = 16;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          rst   = 1'b1;
  logic [CW-1:0] fifo_count = '0;
  logic          fifo_rd_en;
  logic [BW-1:0] fifo_rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_data;
`ifdef FIFO_DRAIN_STATS_EN
  logic [31:0]   drained_cnt;
`endif

  fifo_drain #(.BIT_WIDTH(BW), .CNT_BITW(CW)) dut (
    .clock        (clock),
    .rst          (rst),
    .fifo_count   (fifo_count),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
`ifdef FIFO_DRAIN_STATS_EN
    ,.drained_cnt (drained_cnt)
`endif
  );

  always #5 clock = ~clock;

  logic [BW-1:0] fq[$];
  logic [BW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            pops = 0;
  logic          rd_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Upstream FIFO: rd_en sampled mid-cycle, data returned one cycle later, zero otherwise.
  always @(negedge clock) rd_req = fifo_rd_en;

  always @(posedge clock) begin
    if (rst) begin
      fifo_rd_data <= '0;
    end else if (rd_req) begin
      check("rd_nonempty", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) fifo_rd_data <= fq.pop_front();
      else                fifo_rd_data <= '0;
      fifo_count = CW'(fq.size());
    end else begin
      fifo_rd_data <= '0;
    end
  end

  always @(negedge clock) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_pop", 32'd1, 32'd0);
      else                   check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
      pops++;
    end
  end

  task automatic push_word(input logic [BW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_count = CW'(fq.size());
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    rst = 1'b1;
    fq.delete();
    exp_q.delete();
    fifo_count = '0;
    pops = 0;
    @(posedge clock); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clock);
    @(negedge clock);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int rd_cnt;
    int pushed;
    int cyc;

    // Reset with a non-empty FIFO: no reads while held, read issued after release.
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 5; i++) push_word(BW'(16'hA0 + i));
    @(negedge clock);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    check("rel_rd_en0", 32'(fifo_rd_en), 32'd1);
    @(negedge clock);
    check("rel_rd_en1", 32'(fifo_rd_en), 32'd1);

    // Streaming at full throughput.
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) push_word(BW'(16'h10 + i));
    for (int c = 0; c <= 10; c++) begin
      @(negedge clock);
      if (c == 0) check("str_rd_en_c0", 32'(fifo_rd_en), 32'd1);
      if (c == 1) check("str_valid_c1", 32'(out_valid), 32'd0);
      if (c >= 2 && c <= 9) begin
        check("str_valid", 32'(out_valid), 32'd1);
        check("str_data", 32'(out_data), 32'(16'h10 + c - 2));
      end
      if (c == 10) check("str_valid_c10", 32'(out_valid), 32'd0);
    end
    check("str_sb_empty", 32'(exp_q.size()), 32'd0);
    check("str_pops", 32'(pops), 32'd8);

    // Backpressure: exactly two reads, head held stable.
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) push_word(BW'(16'h10 + i));
    rd_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      rd_cnt += int'(fifo_rd_en);
      if (c >= 2) check("bp_hold", 32'(out_data), 32'h10);
    end
    check("bp_reads", 32'(rd_cnt), 32'd2);
    check("bp_count", 32'(fifo_count), 32'd4);
    check("bp_valid", 32'(out_valid), 32'd1);
    @(posedge clock); #1;
    out_ready = 1'b1;
    drain("bp_drained", 50);
    check("bp_pops", 32'(pops), 32'd6);

    // Underflow: empty FIFO never read, output goes idle.
    rd_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      rd_cnt += int'(fifo_rd_en);
    end
    check("uf_reads", 32'(rd_cnt), 32'd0);
    check("uf_valid", 32'(out_valid), 32'd0);

    // Random consumer stalls and write bursts.
    do_reset();
    pushed = 0;
    cyc = 0;
    while ((pushed < 1000 || exp_q.size() != 0) && cyc < 30000) begin
      @(posedge clock); #1;
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      if (pushed < 1000 && fq.size() < 200 && $urandom_range(0, 3) == 0) begin
        int n;
        n = $urandom_range(1, 8);
        for (int k = 0; k < n && pushed < 1000; k++) begin
          push_word(BW'(pushed));
          pushed++;
        end
      end
    end
    @(negedge clock);
    check("rnd_sb_empty", 32'(exp_q.size()), 32'd0);
    check("rnd_pops", 32'(pops), 32'd1000);
    check("rnd_fifo_empty", 32'(fq.size()), 32'd0);
`ifdef FIFO_DRAIN_STATS_EN
    check("rnd_drained_cnt", drained_cnt, 32'd1000);
`endif

    // Reset mid-stream with the buffer full.
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) push_word(BW'(16'h30 + i));
    repeat (4) @(negedge clock);
    check("mid_valid_two", 32'(out_valid), 32'd1);
    check("mid_rd_en_two", 32'(fifo_rd_en), 32'd0);
    @(posedge clock); #1;
    rst = 1'b1;
    fq.delete();
    exp_q.delete();
    fifo_count = '0;
    pops = 0;
    @(negedge clock);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_word(BW'(16'h50 + i));
    drain("mid_drained", 50);
    check("mid_pops", 32'(pops), 32'd3);
`ifdef FIFO_DRAIN_STATS_EN
    check("mid_drained_cnt", drained_cnt, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 Parameter BIT_WIDTH, default -1, data word width; SHALL be overridden by the instantiating module.
REQ-002 Parameter CNT_BITW, default -1, width of the upstream FIFO count; SHALL equal the FIFO address width.
REQ-003 Port clock  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port fifo_count  input  CNT_BITW  words currently stored in the upstream FIFO.
REQ-006 Port fifo_rd_en  output  1  read strobe to the upstream FIFO.
REQ-007 Port fifo_rd_data  input  BIT_WIDTH  FIFO read data, valid exactly one cycle after fifo_rd_en, zero otherwise.
REQ-008 Port out_valid  output  1  out_data holds a word.
REQ-009 Port out_ready  input  1  downstream accepts the word this cycle.
REQ-010 Port out_data  output  BIT_WIDTH  head word of the internal buffer.

Function
REQ-011 The block SHALL contain a 2-entry buffer with states EMPTY, ONE and TWO, plus a 1-bit in-flight flag set in the cycle after fifo_rd_en=1.
REQ-012 pop SHALL equal out_valid AND out_ready; a word SHALL transfer only on pop.
REQ-013 fifo_rd_en SHALL be 1 iff fifo_count != 0 and (occupancy + in-flight - pop) < 2; this is a combinational function of registered state, fifo_count and out_ready.
REQ-014 In a cycle with in-flight=1, fifo_rd_data SHALL be written to the tail of the buffer; otherwise fifo_rd_data SHALL be ignored.
REQ-015 out_valid SHALL be 1 iff the state is not EMPTY; out_data SHALL be the oldest word, with no combinational path from fifo_rd_data.
REQ-016 State transitions: push without pop SHALL go EMPTY->ONE->TWO; pop without push SHALL go TWO->ONE->EMPTY; simultaneous push and pop SHALL hold the state and shift the head.
REQ-017 Word order SHALL be preserved; no word SHALL be dropped or duplicated.
REQ-018 Latency from fifo_count going 0->1 to out_valid=1 SHALL be 2 cycles: rd_en in cycle 0, capture in cycle 1, out_valid in cycle 2.
REQ-019 With out_ready held at 1 and a non-empty FIFO, throughput SHALL be one word per cycle.
REQ-020 With out_ready=0 in state TWO, or in ONE with in-flight=1, fifo_rd_en SHALL be 0.
REQ-021 When out_valid=1 and out_ready=0, out_data SHALL stay stable.

Reset
REQ-022 While rst=1: state EMPTY, in-flight 0, out_valid 0, out_data 0, fifo_rd_en 0.
REQ-023 Reset asserted mid-transfer SHALL discard buffered and in-flight words; the upstream FIFO SHALL be reset by the same rst.

Configuration
REQ-024 With macro FIFO_DRAIN_STATS_EN defined, the block SHALL add output drained_cnt (32 bits), cleared by rst, incremented on each pop, and wrapping at 2^32.
REQ-025 Without FIFO_DRAIN_STATS_EN, the port and the counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 The buffer-state encodings (EMPTY=0, ONE=1, TWO=2) and the buffer depth constant 2 SHALL live in the shared package segment_pkg.
REQ-027 The 2-entry buffer SHALL be a sub-module skid_buf; fifo_drain holds the read-issue logic and the in-flight flag.

Verification
REQ-028 Reset: rst=1 with fifo_count=5 -> fifo_rd_en=0 and out_valid=0; 1 cycle after release -> fifo_rd_en=1.
REQ-029 Streaming: FIFO preloaded with 8 words 0x10..0x17 and out_ready=1 -> out_data 0x10..0x17 on 8 consecutive cycles, first at cycle 2.
REQ-030 Backpressure: out_ready=0 with 6 words available -> exactly 2 reads issued, out_data=0x10 held, fifo_count stays 4; out_ready=1 -> remaining order intact.
REQ-031 Underflow: fifo_count=0 for 10 cycles -> fifo_rd_en never 1 and out_valid drops after the buffer drains.
REQ-032 Random out_ready and write bursts over 1000 words -> scoreboard shows no loss, duplication or reorder; with FIFO_DRAIN_STATS_EN, drained_cnt=1000.
REQ-033 Reset mid-stream with buffer in TWO -> out_valid=0 next cycle, and post-reset data comes from the restarted FIFO only.
